// File: rtl/uart_api_dc.sv
// uart_api_dc: UART 8N1 command frames to 32-bit SPI DAC writes, with an LDAC strobe after each complete frame.
// Optional status byte transmitter on o_tx is built only when UART_ACK_EN is defined.
module uart_api_dc #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 115200,
    parameter int FRAME_WORDS    = 62,
    parameter int NUM_CS         = 24,
    parameter int SCLK_DIV       = 4,
    parameter int LDAC_CYCLES    = 10,
    parameter int RX_TIMEOUT_CYC = 2_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic              o_tx,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_ldac_n
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_LDAC} spi_state_t;

    rx_state_t   rx_state;
    spi_state_t  spi_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, byte_data;
    logic        byte_valid, byte_err;

    logic [15:0]       word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word_acc, word_next, to_cnt;
    logic [NUM_CS-1:0] sel_mask, hdr_mask, buf_mask;
    logic [31:0]       buf_data;
    logic              buf_full, end_pend, end_any, err_flag, err_clr;
    logic              mid_frame, timeout_hit, abort, buf_take, end_take;

    logic [31:0] sp_cnt, sh_reg;
    logic [5:0]  bit_cnt;
    logic        ack_good, ack_nosel;

    // UART receiver: bit timing is re-centred on the confirmed start bit
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta <= 1'b1; rx_sync <= 1'b1; rx_prev <= 1'b1;
            rx_state <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_shift <= '0;
            byte_data <= '0; byte_valid <= 1'b0; byte_err <= 1'b0;
        end else begin
            rx_meta <= i_rx; rx_sync <= rx_meta; rx_prev <= rx_sync;
            byte_valid <= 1'b0; byte_err <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_sync) begin rx_state <= RX_START; rx_cnt <= '0; end
                RX_START: begin
                    if (rx_cnt == 32'(HALF_CYC-1)) begin
                        rx_cnt <= '0; rx_bit <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (rx_cnt == 32'(BIT_CYC-1)) begin
                        rx_cnt <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else rx_bit <= rx_bit + 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: begin
                    if (rx_cnt == 32'(BIT_CYC-1)) begin
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin byte_valid <= 1'b1; byte_data <= rx_shift; end
                        else byte_err <= 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
            endcase
        end
    end

    assign word_next   = {word_acc[23:0], byte_data};
    assign mid_frame   = (word_idx != '0) || (byte_idx != '0);
    assign timeout_hit = mid_frame && !byte_valid && (to_cnt == 32'(RX_TIMEOUT_CYC-1));
    assign abort       = byte_err || timeout_hit;
    assign buf_take    = (spi_state == S_IDLE) && buf_full;
    assign end_take    = (spi_state == S_IDLE) && !buf_full && end_pend;

    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_hdr
            assign hdr_mask[gi] = ~word_next[31-gi];
        end
    endgenerate

    // Frame assembler; frame end is handed to the SPI engine so the next frame can start at once
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_idx <= '0; byte_idx <= '0; word_acc <= '0; to_cnt <= '0;
            sel_mask <= '0; buf_mask <= '0; buf_data <= '0; buf_full <= 1'b0;
            end_pend <= 1'b0; end_any <= 1'b0; err_flag <= 1'b0;
        end else begin
            if (buf_take) buf_full <= 1'b0;
            if (end_take) end_pend <= 1'b0;
            if (err_clr)  err_flag <= 1'b0;
            if (!mid_frame || byte_valid || byte_err || timeout_hit) to_cnt <= '0;
            else to_cnt <= to_cnt + 1'b1;
            if (abort) begin
                word_idx <= '0; byte_idx <= '0;
            end else if (byte_valid) begin
                word_acc <= word_next;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) begin
                    if (word_idx == '0) sel_mask <= hdr_mask;
                    else if (|sel_mask) begin
                        if (buf_full) err_flag <= 1'b1;
                        else begin buf_full <= 1'b1; buf_data <= word_next; buf_mask <= sel_mask; end
                    end
                    if (word_idx == 16'(FRAME_WORDS-1)) begin
                        word_idx <= '0; end_pend <= 1'b1; end_any <= |sel_mask;
                    end else word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

    // SPI engine (CPOL=0) and LDAC strobe
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            spi_state <= S_IDLE; sp_cnt <= '0; sh_reg <= '0; bit_cnt <= '0;
            o_sclk <= 1'b0; o_mosi <= 1'b0; o_cs_n <= '1; o_ldac_n <= 1'b1;
            ack_good <= 1'b0; ack_nosel <= 1'b0;
        end else begin
            ack_good <= 1'b0; ack_nosel <= 1'b0;
            case (spi_state)
                S_IDLE: begin
                    sp_cnt <= '0;
                    if (buf_full) begin
                        o_cs_n <= ~buf_mask; sh_reg <= buf_data; o_mosi <= buf_data[31];
                        spi_state <= S_LOAD;
                    end else if (end_pend) begin
                        if (end_any) begin o_ldac_n <= 1'b0; spi_state <= S_LDAC; end
                        else ack_nosel <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (sp_cnt == 32'(SCLK_DIV-1)) begin
                        sp_cnt <= '0; bit_cnt <= '0; o_sclk <= 1'b1; spi_state <= S_SHIFT;
                    end else sp_cnt <= sp_cnt + 1'b1;
                end
                S_SHIFT: begin
                    if (sp_cnt == 32'(SCLK_DIV-1)) begin
                        sp_cnt <= '0;
                        if (o_sclk) begin
                            o_sclk <= 1'b0;
                            if (bit_cnt == 6'd31) spi_state <= S_HOLD;
                            else bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            o_sclk <= 1'b1; o_mosi <= sh_reg[30]; sh_reg <= {sh_reg[30:0], 1'b0};
                        end
                    end else sp_cnt <= sp_cnt + 1'b1;
                end
                S_HOLD: begin
                    if (sp_cnt == 32'(SCLK_DIV-1)) begin
                        sp_cnt <= '0; o_cs_n <= '1; o_mosi <= 1'b0; spi_state <= S_GAP;
                    end else sp_cnt <= sp_cnt + 1'b1;
                end
                S_GAP: begin
                    if (sp_cnt == 32'(2*SCLK_DIV-1)) begin sp_cnt <= '0; spi_state <= S_IDLE; end
                    else sp_cnt <= sp_cnt + 1'b1;
                end
                default: begin
                    if (sp_cnt == 32'(LDAC_CYCLES-1)) begin
                        sp_cnt <= '0; o_ldac_n <= 1'b1; ack_good <= 1'b1; spi_state <= S_IDLE;
                    end else sp_cnt <= sp_cnt + 1'b1;
                end
            endcase
        end
    end

`ifdef UART_ACK_EN
    logic        ack_pend, tx_busy;
    logic [7:0]  ack_code;
    logic [8:0]  tx_shift;
    logic [3:0]  tx_bitn;
    logic [31:0] tx_cnt;

    // Status byte transmitter; a newer event overrides a status not yet started
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx <= 1'b1; ack_pend <= 1'b0; ack_code <= '0; tx_busy <= 1'b0;
            tx_shift <= '0; tx_bitn <= '0; tx_cnt <= '0; err_clr <= 1'b0;
        end else begin
            err_clr <= 1'b0;
            if (!tx_busy && ack_pend) begin
                ack_pend <= 1'b0; tx_busy <= 1'b1; o_tx <= 1'b0;
                tx_shift <= {1'b1, ack_code}; tx_bitn <= '0; tx_cnt <= '0;
            end else if (tx_busy) begin
                if (tx_cnt == 32'(BIT_CYC-1)) begin
                    tx_cnt <= '0;
                    if (tx_bitn == 4'd9) begin tx_busy <= 1'b0; err_clr <= 1'b1; end
                    else begin
                        o_tx <= tx_shift[0]; tx_shift <= {1'b1, tx_shift[8:1]};
                        tx_bitn <= tx_bitn + 1'b1;
                    end
                end else tx_cnt <= tx_cnt + 1'b1;
            end
            if (abort || ack_good || ack_nosel) begin
                ack_pend <= 1'b1;
                ack_code <= (abort || err_flag) ? 8'hEE : (ack_good ? 8'hA5 : 8'hE1);
            end
        end
    end
`else
    logic unused_ack;
    assign o_tx       = 1'b1;
    assign err_clr    = 1'b0;
    assign unused_ack = ^{err_flag, ack_good, ack_nosel};
`endif

endmodule

// File: tb/tb_uart_api_dc.sv
// Randomised frame bench for uart_api_dc: a frame-level model fills an event queue, a monitor decodes SPI/LDAC (and o_tx) and compares.
module tb_uart_api_dc;
    localparam int CLK_FREQ = 8_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int FW       = 4;
    localparam int NCS      = 24;
    localparam int SDIV     = 2;
    localparam int LDAC_W   = 10;
    localparam int TO_CYC   = 600;
    localparam logic [NCS-1:0] ALL1 = '1;

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_rx = 1'b1;
    logic o_tx, o_sclk, o_mosi, o_ldac_n;
    logic [NCS-1:0] o_cs_n;

    always #5 clk = ~clk;

    uart_api_dc #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FRAME_WORDS(FW), .NUM_CS(NCS),
                  .SCLK_DIV(SDIV), .LDAC_CYCLES(LDAC_W), .RX_TIMEOUT_CYC(TO_CYC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rx(i_rx), .o_tx(o_tx), .o_sclk(o_sclk),
        .o_mosi(o_mosi), .o_cs_n(o_cs_n), .o_ldac_n(o_ldac_n));

    typedef struct packed {
        logic           is_ldac;
        logic [NCS-1:0] mask;
        logic [31:0]    data;
    } ev_t;

    ev_t exp_q[$];
    logic [7:0] ack_q[$];
    logic [31:0] pay [FW-1];
    int vectors = 0;
    int miscompares = 0;
    int sclk_idle_err = 0;
    int tx_err = 0;
    bit in_word = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic uart_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk); i_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            repeat (BIT) @(negedge clk);
        end
        i_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (BIT) @(negedge clk);
        i_rx = 1'b1;
        repeat ($urandom_range(0, 16)) @(negedge clk);
    endtask

    // Frame model: a zero header bit selects a chip; each completed payload word is one SPI write,
    // a complete frame with any chip selected ends in one LDAC pulse.
    task automatic send_frame(input logic [31:0] hdr, input int nbytes, input int bad_at);
        logic [NCS-1:0] m;
        logic [31:0] w;
        logic [7:0] b;
        ev_t e;
        bit aborted;
        aborted = 0;
        for (int k = 0; k < NCS; k++) m[k] = ~hdr[31-k];
        for (int i = 0; i < nbytes; i++) begin
            w = (i / 4 == 0) ? hdr : pay[i/4 - 1];
            b = 8'(w >> (8 * (3 - i % 4)));
            if (i == bad_at) begin
                uart_byte(b, 1'b1);
                aborted = 1;
                break;
            end
            if (i % 4 == 3 && i / 4 >= 1 && m != '0) begin
                e.is_ldac = 1'b0; e.mask = m; e.data = w;
                exp_q.push_back(e);
            end
            if (i == 4 * FW - 1 && m != '0) begin
                e.is_ldac = 1'b1; e.mask = m; e.data = '0;
                exp_q.push_back(e);
            end
            uart_byte(b, 1'b0);
        end
        if (aborted || nbytes < 4 * FW) ack_q.push_back(8'hEE);
        else ack_q.push_back(m != '0 ? 8'hA5 : 8'hE1);
    endtask

    function automatic logic [31:0] rand_hdr();
        logic [23:0] sel;
        case ($urandom_range(0, 3))
            0: sel = ~(24'd1 << $urandom_range(0, 23));
            1: sel = ~((24'd1 << $urandom_range(0, 23)) | (24'd1 << $urandom_range(0, 23)));
            2: sel = 24'($urandom);
            default: sel = '1;
        endcase
        return {sel, 8'($urandom)};
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < FW - 1; i++) pay[i] = $urandom;
    endtask

    // SPI / LDAC monitor
    initial begin
        logic [NCS-1:0] cur_mask;
        logic [31:0] cur_data;
        int rises, ldac_cnt;
        bit cs_bad, prev_sclk, prev_ldac;
        ev_t e;
        cur_mask = '0; cur_data = '0; rises = 0; ldac_cnt = 0;
        cs_bad = 0; prev_sclk = 0; prev_ldac = 1;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                in_word = 0; prev_sclk = 0; prev_ldac = 1; ldac_cnt = 0;
            end else begin
                if (!in_word && o_cs_n != ALL1) begin
                    in_word = 1; cur_mask = ~o_cs_n; rises = 0; cur_data = '0; cs_bad = 0;
                end
                if (in_word) begin
                    if (o_sclk && !prev_sclk) rises++;
                    if (!o_sclk && prev_sclk) cur_data = {cur_data[30:0], o_mosi};
                    if (o_cs_n == ALL1) begin
                        in_word = 0;
                        $display("spi  cs_mask=%h data=%h sclk_rises=%0d", cur_mask, cur_data, rises);
                        if (exp_q.size() == 0) chk("spi_unexpected", exp_q.size(), 1);
                        else begin
                            e = exp_q.pop_front();
                            chk("spi_kind", e.is_ldac, 0);
                            chk("spi_mask", cur_mask, e.mask);
                            chk("spi_data", cur_data, e.data);
                            chk("spi_sclk_rises", rises, 32);
                            chk("spi_cs_stable", cs_bad, 0);
                        end
                    end else if (~o_cs_n != cur_mask) cs_bad = 1;
                end else if (o_sclk != prev_sclk) sclk_idle_err++;
                if (o_ldac_n == 1'b0) ldac_cnt++;
                else if (!prev_ldac) begin
                    $display("ldac width=%0d", ldac_cnt);
                    if (exp_q.size() == 0) chk("ldac_unexpected", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("ldac_kind", e.is_ldac, 1);
                        chk("ldac_width", ldac_cnt, LDAC_W);
                    end
                    ldac_cnt = 0;
                end
`ifndef UART_ACK_EN
                if (o_tx !== 1'b1) tx_err++;
`endif
                prev_sclk = o_sclk;
                prev_ldac = o_ldac_n;
            end
        end
    end

`ifdef UART_ACK_EN
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (i_rst && o_tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (BIT) @(negedge clk);
                    v[b] = o_tx;
                end
                repeat (BIT) @(negedge clk);
                $display("ack  byte=%h", v);
                if (ack_q.size() == 0) chk("ack_unexpected", ack_q.size(), 1);
                else chk("ack_code", v, ack_q.pop_front());
            end
        end
    end
`endif

    initial begin
        i_rst = 1'b0; i_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_sclk", o_sclk, 0);
        chk("rst_mosi", o_mosi, 0);
        chk("rst_cs_n", o_cs_n, ALL1);
        chk("rst_ldac_n", o_ldac_n, 1);
        repeat (10) @(negedge clk);
        i_rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_cs_n", o_cs_n, ALL1);
        chk("post_rst_ldac_n", o_ldac_n, 1);
        chk("post_rst_sclk", o_sclk, 0);

        // channel 0 with fixed payload
        pay[0] = 32'h12345678; pay[1] = 32'h9ABCDEF0; pay[2] = 32'h00010002;
        send_frame(32'h7FFFFFFF, 4 * FW, -1);
        // broadcast to chips 0 and 1
        rand_payload(); send_frame(32'h3FFFFFFF, 4 * FW, -1);
        // no chip selected, then a normal frame
        rand_payload(); send_frame(32'hFFFFFFFF, 4 * FW, -1);
        rand_payload(); send_frame(32'hDFFFFF00, 4 * FW, -1);
        // partial frame aborted by idle timeout, then channel 5
        rand_payload(); send_frame(32'hEFFFFFFF, 10, -1);
        repeat (TO_CYC + 400) @(negedge clk);
        rand_payload(); send_frame(32'hFBFFFFFF, 4 * FW, -1);
        // stop-bit error inside payload word 2, then a clean frame
        rand_payload(); send_frame(32'hF7FFFFFF, 4 * FW, 9);
        repeat (200) @(negedge clk);
        rand_payload(); send_frame(32'h7FFFFFFF, 4 * FW, -1);
        // randomised frames
        for (int f = 0; f < 6; f++) begin
            rand_payload();
            send_frame(rand_hdr(), 4 * FW, -1);
        end

        for (int i = 0; i < 5000 && (exp_q.size() != 0 || ack_pending() || in_word); i++)
            @(negedge clk);
        chk("drain_events", exp_q.size(), 0);
        chk("sclk_idle_toggles", sclk_idle_err, 0);
`ifdef UART_ACK_EN
        chk("drain_acks", ack_q.size(), 0);
`else
        chk("tx_idle_high", tx_err, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic bit ack_pending();
`ifdef UART_ACK_EN
        return ack_q.size() != 0;
`else
        return 1'b0;
`endif
    endfunction

endmodule
